vga_sync_gen: RTL and testbench

Upstream video-timing stage for the 640x480 game display. Generates the pixel-rate strobe, the horizontal and vertical scan counters, and the sync and blanking signals. Its `pix_x`/`pix_y` feed the game graphics stage directly; that stage's refresh detection requires `pix_y` to sweep through the vertical blanking lines (e.g. line 481). The same `hsync`/`vsync`/`video_on` go to the HDMI/TMDS encoder alongside the graphics RGB.

---
 rtl/vga_sync_gen.sv | 120 ++++++++++++
 tb/tb_vga_sync_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA video-timing generator. It produces the pixel strobe, the scan counters,
// registered sync/blank decode, and single-cycle line and frame start pulses.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 1,
  parameter int SYNC_POL  = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic       SYNC_ON  = (SYNC_POL != 0);

  // Counters are 10 bits wide, so any longer timing would silently alias.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
    $error("vga_sync_gen: CLK_DIV must be in 1..16");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_q, video_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    div_d = div_q + DIV_ONE;
    x_d   = x_q;
    y_d   = y_q;

    if (tick) begin
      div_d = '0;
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // Decode from the next-state counters so the registered levels line up with pix_x/pix_y.
    hsync_d = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? SYNC_ON : !SYNC_ON;
    vsync_d = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? SYNC_ON : !SYNC_ON;
    video_d = (x_d < H_VIS) && (y_d < V_VIS);
    line_d  = tick && (x_q == H_LAST);
    frame_d = line_d && (y_q == V_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= !SYNC_ON;
      vsync_q <= !SYNC_ON;
      video_q <= 1'b1;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign p_tick      = tick;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen. Four instances (defaults, CLK_DIV=4, small timing,
// small timing with CLK_DIV=3 and active-high sync) are checked every cycle against a position formula.
module tb_vga_sync_gen;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic       d_p_tick, d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start;
  logic [9:0] d_pix_x, d_pix_y;
  logic       v_p_tick, v_hsync, v_vsync, v_video_on, v_line_start, v_frame_start;
  logic [9:0] v_pix_x, v_pix_y;
  logic       s_p_tick, s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
  logic [9:0] s_pix_x, s_pix_y;
  logic       p_p_tick, p_hsync, p_vsync, p_video_on, p_line_start, p_frame_start;
  logic [9:0] p_pix_x, p_pix_y;

  vga_sync_gen u_def (
    .clk(clk), .reset(reset), .p_tick(d_p_tick), .pix_x(d_pix_x), .pix_y(d_pix_y),
    .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on),
    .line_start(d_line_start), .frame_start(d_frame_start)
  );

  vga_sync_gen #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .reset(reset), .p_tick(v_p_tick), .pix_x(v_pix_x), .pix_y(v_pix_y),
    .hsync(v_hsync), .vsync(v_vsync), .video_on(v_video_on),
    .line_start(v_line_start), .frame_start(v_frame_start)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_small (
    .clk(clk), .reset(reset), .p_tick(s_p_tick), .pix_x(s_pix_x), .pix_y(s_pix_y),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
    .line_start(s_line_start), .frame_start(s_frame_start)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .CLK_DIV(3), .SYNC_POL(1)
  ) u_pol (
    .clk(clk), .reset(reset), .p_tick(p_p_tick), .pix_x(p_pix_x), .pix_y(p_pix_y),
    .hsync(p_hsync), .vsync(p_vsync), .video_on(p_video_on),
    .line_start(p_line_start), .frame_start(p_frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  // k = rising edges since reset release; the expected scan position is derived from k alone.
  task automatic check_timing(
    input string tag, input int k,
    input int hd, input int hf, input int hs, input int hb,
    input int vd, input int vf, input int vs, input int vb,
    input int div, input int pol,
    input logic pt, input logic [9:0] x, input logic [9:0] y,
    input logic hsy, input logic vsy, input logic von, input logic ls, input logic fs
  );
    int   ht, vt, p, ex, ey;
    logic on_lvl, e_hs, e_vs;
    ht     = hd + hf + hs + hb;
    vt     = vd + vf + vs + vb;
    p      = k / div;
    ex     = p % ht;
    ey     = (p / ht) % vt;
    on_lvl = (pol != 0);
    e_hs   = (ex >= hd + hf && ex < hd + hf + hs) ? on_lvl : !on_lvl;
    e_vs   = (ey >= vd + vf && ey < vd + vf + vs) ? on_lvl : !on_lvl;
    check({tag, ".p_tick"},      k, 32'(pt),  32'((k % div) == (div - 1)));
    check({tag, ".pix_x"},       k, 32'(x),   ex);
    check({tag, ".pix_y"},       k, 32'(y),   ey);
    check({tag, ".hsync"},       k, 32'(hsy), 32'(e_hs));
    check({tag, ".vsync"},       k, 32'(vsy), 32'(e_vs));
    check({tag, ".video_on"},    k, 32'(von), 32'((ex < hd) && (ey < vd)));
    check({tag, ".line_start"},  k, 32'(ls),  32'((k != 0) && (k % (ht * div) == 0)));
    check({tag, ".frame_start"}, k, 32'(fs),  32'((k != 0) && (k % (ht * vt * div) == 0)));
  endtask

  task automatic check_all(input int k);
    check_timing("def", k, 640, 16, 96, 48, 480, 10, 2, 33, 1, 0,
                 d_p_tick, d_pix_x, d_pix_y, d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start);
    check_timing("div4", k, 640, 16, 96, 48, 480, 10, 2, 33, 4, 0,
                 v_p_tick, v_pix_x, v_pix_y, v_hsync, v_vsync, v_video_on, v_line_start, v_frame_start);
    check_timing("small", k, 8, 2, 3, 3, 6, 2, 2, 3, 1, 0,
                 s_p_tick, s_pix_x, s_pix_y, s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start);
    check_timing("pol", k, 8, 2, 3, 3, 6, 2, 2, 3, 3, 1,
                 p_p_tick, p_pix_x, p_pix_y, p_hsync, p_vsync, p_video_on, p_line_start, p_frame_start);
  endtask

  initial begin
    int   k;
    int   def_hs_low, def_ls, def_first_blank;
    int   div4_ls, div4_fs, div4_pt;
    int   small_vs, small_fs, pol_hs, pol_fs;
    logic seen_y7, found;

    checks = 0; errors = 0;
    def_hs_low = 0; def_ls = 0; def_first_blank = -1;
    div4_ls = 0; div4_fs = 0; div4_pt = 0;
    small_vs = 0; small_fs = 0; pol_hs = 0; pol_fs = 0;
    seen_y7 = 1'b0; found = 1'b0;

    // Step 1: reset held, every instance at its reset values.
    reset = 1'b0;
    @(negedge clk);
    check_all(0);

    // Step 2: release and run 3300 cycles (one CLK_DIV=4 line, many small frames).
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 3300; i++) begin
      @(negedge clk);
      k++;
      check_all(k);
      if (k < 800 && !d_hsync) def_hs_low++;
      if (d_line_start) def_ls++;
      if (!d_video_on && def_first_blank < 0) def_first_blank = k;
      if (v_line_start) div4_ls++;
      if (v_frame_start) div4_fs++;
      if (v_p_tick) div4_pt++;
      if (k <= 208 && !s_vsync) small_vs++;
      if (s_pix_y == 10'd7) seen_y7 = 1'b1;
      if (s_frame_start) small_fs++;
      if (k < 48 && p_hsync) pol_hs++;
      if (p_frame_start) pol_fs++;
    end

    // Step 3: aggregate counts, hand-computed from the timing parameters.
    check("def.hsync_low_cycles_line0", k, def_hs_low, 96);
    check("def.line_start_pulses", k, def_ls, 4);
    check("def.first_blank_x", k, def_first_blank, 640);
    check("div4.line_start_pulses", k, div4_ls, 1);
    check("div4.frame_start_pulses", k, div4_fs, 0);
    check("div4.p_tick_high_cycles", k, div4_pt, 825);
    check("small.vsync_low_cycles_frame0", k, small_vs, 32);
    check("small.blank_line_visited", k, 32'(seen_y7), 1);
    check("small.frame_start_pulses", k, small_fs, 15);
    check("pol.hsync_high_cycles_line0", k, pol_hs, 9);
    check("pol.frame_start_pulses", k, pol_fs, 5);

    // Step 4: run on to pol at (11,5), inside its hsync, then reset between clock edges.
    for (int i = 0; i < 1000; i++) begin
      if (p_pix_x == 10'd11 && p_pix_y == 10'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
      check_all(k);
    end
    check("mid.wait_reached_11_5", k, 32'(found), 1);
    check("mid.pol_hsync_before_reset", k, 32'(p_hsync), 1);
    #2 reset = 1'b0;
    #1 check_all(0);
    @(negedge clk);
    check_all(0);

    // Step 5: counting restarts from (0,0) after release.
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      k++;
      check_all(k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
